// File: rtl/switch_pio_pkg.sv
// Shared register addresses and edge-capture encodings for the switch input port.
package switch_pio_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,
        ADDR_MASK = 2'd1,
        ADDR_EDGE = 2'd2,
        ADDR_RAW  = 2'd3
    } reg_addr_t;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/switch_debounce_pio_debounce_bit.sv
// One switch input: two-flop synchroniser, then a counter that only accepts
// a new level after it has differed from the accepted level for DEBOUNCE_CYCLES clocks.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic sync,
    output logic stable,
    output logic upd
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic [CNT_W-1:0] count;

    // upd is combinational so the top can capture the edge on the same clock that stable moves
    assign upd = (sync != stable) && (count == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            stable <= 1'b0;
            count  <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
            if (sync == stable) begin
                count <= '0;
            end else if (count == CNT_MAX) begin
                stable <= sync;
                count  <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/switch_debounce_pio.sv
// Avalon-MM switch input port: debounced data, sticky edge capture and a maskable level IRQ.
module switch_debounce_pio
    import switch_pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_MODE       = EDGE_ANY
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [WIDTH-1:0]  switches_export,
    input  logic [1:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              irq
);

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] upd;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;
    logic [31:0]      read_value;
    logic             unused_wdata;

    assign unused_wdata = ^avs_writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk_clk),
            .rst_n  (reset_reset_n),
            .raw    (switches_export[i]),
            .sync   (sync[i]),
            .stable (stable[i]),
            .upd    (upd[i])
        );
    end

    // On an update the new accepted level equals sync, which selects rise vs fall
    always_comb begin
        edge_set = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (EDGE_MODE)
                EDGE_RISE: edge_set[i] = upd[i] & sync[i];
                EDGE_FALL: edge_set[i] = upd[i] & ~sync[i];
                default:   edge_set[i] = upd[i];
            endcase
        end
    end

    assign edge_clr = (avs_write && avs_address == ADDR_EDGE) ? avs_writedata[WIDTH-1:0] : '0;

    always_comb begin
        read_value = '0;
        case (avs_address)
            ADDR_DATA: read_value[WIDTH-1:0] = stable;
            ADDR_MASK: read_value[WIDTH-1:0] = irq_mask;
            ADDR_EDGE: read_value[WIDTH-1:0] = edge_cap;
            ADDR_RAW:  read_value[WIDTH-1:0] = sync;
            default:   read_value = '0;
        endcase
    end

    // Set is ORed after the clear so a fresh edge survives a same-cycle clear
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            irq_mask     <= '0;
            edge_cap     <= '0;
            avs_readdata <= '0;
        end else begin
            if (avs_write && avs_address == ADDR_MASK) begin
                irq_mask <= avs_writedata[WIDTH-1:0];
            end
            edge_cap <= (edge_cap & ~edge_clr) | edge_set;
            if (avs_read) begin
                avs_readdata <= read_value;
            end
        end
    end

    assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_switch_debounce_pio.sv
// Self-checking bench: directed scenarios plus randomized traffic against a sample-history model.
module tb_switch_debounce_pio;
    import switch_pio_pkg::*;

    localparam int WIDTH = 8;
    localparam int DC    = 4;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [7:0]  switches_export;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    switch_debounce_pio #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DC),
        .EDGE_MODE       (EDGE_ANY)
    ) dut (
        .clk_clk         (clk_clk),
        .reset_reset_n   (reset_reset_n),
        .switches_export (switches_export),
        .avs_address     (avs_address),
        .avs_read        (avs_read),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_readdata    (avs_readdata),
        .irq             (irq)
    );

    always #5 clk_clk = ~clk_clk;

    // Model: hist[k] is the pin value sampled k edges ago; a level is accepted once the
    // last DC synchronised samples (two edges old and older) all differ from the accepted level.
    logic [7:0]  hist [0:DC+1];
    logic [7:0]  m_stable;
    logic [7:0]  m_mask;
    logic [7:0]  m_edge;
    logic [31:0] m_rdata;

    function automatic logic m_irq();
        return |(m_edge & m_mask);
    endfunction

    task automatic model_reset();
        for (int k = 0; k <= DC + 1; k++) hist[k] = '0;
        m_stable = '0;
        m_mask   = '0;
        m_edge   = '0;
        m_rdata  = '0;
    endtask

    task automatic model_edge();
        logic [7:0] acc;
        logic [7:0] clr;
        for (int k = DC + 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = switches_export;
        for (int i = 0; i < 8; i++) begin
            acc[i] = 1'b1;
            for (int k = 2; k <= DC + 1; k++) begin
                if (hist[k][i] == m_stable[i]) acc[i] = 1'b0;
            end
        end
        if (avs_read) begin
            case (avs_address)
                2'd0:    m_rdata = {24'h0, m_stable};
                2'd1:    m_rdata = {24'h0, m_mask};
                2'd2:    m_rdata = {24'h0, m_edge};
                default: m_rdata = {24'h0, hist[2]};
            endcase
        end
        clr = (avs_write && avs_address == 2'd2) ? avs_writedata[7:0] : 8'h00;
        m_edge = (m_edge & ~clr) | acc;
        if (avs_write && avs_address == 2'd1) m_mask = avs_writedata[7:0];
        m_stable = m_stable ^ acc;
    endtask

    task automatic step();
        @(posedge clk_clk);
        if (reset_reset_n) model_edge();
        @(negedge clk_clk);
    endtask

    task automatic bus(input logic rd, input logic wr, input logic [1:0] a, input logic [31:0] d);
        avs_read      = rd;
        avs_write     = wr;
        avs_address   = a;
        avs_writedata = d;
        step();
        avs_read  = 1'b0;
        avs_write = 1'b0;
    endtask

    task automatic test_reset();
        reset_reset_n   = 1'b0;
        switches_export = 8'h00;
        avs_read        = 1'b0;
        avs_write       = 1'b0;
        avs_address     = 2'd0;
        avs_writedata   = '0;
        model_reset();
        repeat (2) @(negedge clk_clk);
        checks++;
        if (avs_readdata !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: readdata=%h irq=%b expected 0/0", avs_readdata, irq);
        end
        reset_reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus(1'b1, 1'b0, a[1:0], 32'h0);
            checks++;
            if (avs_readdata !== 32'h0 || avs_readdata !== m_rdata || irq !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_read addr %0d: got %h irq=%b expected 00000000 irq=0", a, avs_readdata, irq);
            end
        end
    endtask

    task automatic test_debounce_latency();
        logic [31:0] exp;
        switches_export = 8'h05;
        // stable moves on the 6th edge, so a read issued on the 7th edge is the first to see it
        for (int k = 1; k <= 8; k++) begin
            bus(1'b1, 1'b0, ADDR_DATA, 32'h0);
            exp = (k >= 7) ? 32'h05 : 32'h0;
            checks++;
            if (avs_readdata !== exp || avs_readdata !== m_rdata || irq !== 1'b0) begin
                errors++;
                $display("[TB] FAIL latency edge %0d: got %h irq=%b expected %h irq=0", k, avs_readdata, irq, exp);
            end
        end
        bus(1'b1, 1'b0, ADDR_EDGE, 32'h0);
        checks++;
        if (avs_readdata !== 32'h05 || avs_readdata !== m_rdata || irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL edge_after_press: got %h irq=%b expected 00000005 irq=0", avs_readdata, irq);
        end
    endtask

    task automatic test_mask_irq();
        bus(1'b0, 1'b1, ADDR_MASK, 32'h04);
        checks++;
        if (irq !== 1'b1 || irq !== m_irq()) begin
            errors++;
            $display("[TB] FAIL irq_after_mask: got %b expected 1", irq);
        end
        bus(1'b0, 1'b1, ADDR_EDGE, 32'h01);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL irq_after_clear_other: got %b expected 1", irq);
        end
        bus(1'b1, 1'b0, ADDR_EDGE, 32'h0);
        checks++;
        if (avs_readdata !== 32'h04 || avs_readdata !== m_rdata) begin
            errors++;
            $display("[TB] FAIL edge_partial_clear: got %h expected 00000004", avs_readdata);
        end
        bus(1'b0, 1'b1, ADDR_EDGE, 32'h04);
        checks++;
        if (irq !== 1'b0 || irq !== m_irq()) begin
            errors++;
            $display("[TB] FAIL irq_after_clear: got %b expected 0", irq);
        end
        bus(1'b1, 1'b0, ADDR_MASK, 32'h0);
        checks++;
        if (avs_readdata !== 32'h04 || avs_readdata !== m_rdata) begin
            errors++;
            $display("[TB] FAIL mask_readback: got %h expected 00000004", avs_readdata);
        end
    endtask

    task automatic test_glitch();
        logic seen = 1'b0;
        switches_export = 8'h85;
        for (int k = 0; k < 15; k++) begin
            if (k == 3) switches_export = 8'h05;
            bus(1'b1, 1'b0, ADDR_RAW, 32'h0);
            if (avs_readdata === 32'h85) seen = 1'b1;
            checks++;
            if (avs_readdata !== m_rdata) begin
                errors++;
                $display("[TB] FAIL glitch_raw cycle %0d: got %h expected %h", k, avs_readdata, m_rdata);
            end
        end
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("[TB] FAIL glitch_raw_visible: saw=%b expected 1", seen);
        end
        bus(1'b1, 1'b0, ADDR_DATA, 32'h0);
        checks++;
        if (avs_readdata !== 32'h05 || avs_readdata !== m_rdata) begin
            errors++;
            $display("[TB] FAIL glitch_data: got %h expected 00000005", avs_readdata);
        end
        bus(1'b1, 1'b0, ADDR_EDGE, 32'h0);
        checks++;
        if (avs_readdata !== 32'h0 || avs_readdata !== m_rdata || irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL glitch_edge: got %h irq=%b expected 00000000 irq=0", avs_readdata, irq);
        end
    endtask

    task automatic test_set_wins();
        switches_export = 8'h07;
        repeat (5) bus(1'b0, 1'b0, ADDR_DATA, 32'h0);
        bus(1'b0, 1'b1, ADDR_EDGE, 32'h02);
        bus(1'b1, 1'b0, ADDR_EDGE, 32'h0);
        checks++;
        if (avs_readdata !== 32'h02 || avs_readdata !== m_rdata) begin
            errors++;
            $display("[TB] FAIL set_wins_edge: got %h expected 00000002", avs_readdata);
        end
        bus(1'b1, 1'b0, ADDR_DATA, 32'h0);
        checks++;
        if (avs_readdata !== 32'h07 || avs_readdata !== m_rdata) begin
            errors++;
            $display("[TB] FAIL set_wins_data: got %h expected 00000007", avs_readdata);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp;
        switches_export = 8'h0F;
        repeat (3) bus(1'b0, 1'b0, ADDR_DATA, 32'h0);
        reset_reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (avs_readdata !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: readdata=%h irq=%b expected 0/0", avs_readdata, irq);
        end
        step();
        reset_reset_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            bus(1'b1, 1'b0, ADDR_DATA, 32'h0);
            exp = (k >= 7) ? 32'h0F : 32'h0;
            checks++;
            if (avs_readdata !== exp || avs_readdata !== m_rdata) begin
                errors++;
                $display("[TB] FAIL post_reset_latency edge %0d: got %h expected %h", k, avs_readdata, exp);
            end
        end
        bus(1'b1, 1'b0, ADDR_MASK, 32'h0);
        checks++;
        if (avs_readdata !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_mask: got %h irq=%b expected 00000000 irq=0", avs_readdata, irq);
        end
        bus(1'b1, 1'b0, ADDR_EDGE, 32'h0);
        checks++;
        if (avs_readdata !== 32'h0F || avs_readdata !== m_rdata) begin
            errors++;
            $display("[TB] FAIL post_reset_edge: got %h expected 0000000F", avs_readdata);
        end
    endtask

    task automatic test_random();
        int hold = 0;
        logic rd;
        logic wr;
        bus(1'b0, 1'b1, ADDR_EDGE, 32'hFF);
        bus(1'b0, 1'b1, ADDR_MASK, $urandom);
        for (int n = 0; n < 600; n++) begin
            if (hold == 0) begin
                switches_export = 8'($urandom);
                hold = $urandom_range(1, 8);
            end
            hold--;
            rd = 1'($urandom_range(0, 1));
            wr = ($urandom_range(0, 3) == 0);
            bus(rd, wr, 2'($urandom_range(0, 3)), $urandom);
            checks++;
            if (avs_readdata !== m_rdata || irq !== m_irq()) begin
                errors++;
                $display("[TB] FAIL random cycle %0d: readdata=%h irq=%b expected %h irq=%b",
                         n, avs_readdata, irq, m_rdata, m_irq());
            end
        end
    endtask

    initial begin
        test_reset();
        test_debounce_latency();
        test_mask_irq();
        test_glitch();
        test_set_wins();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
